// File: rtl/pacman_direction_buffer.sv
// Pac-Man direction controller: button sync/debounce, turn buffering
// ("pre-turn") against maze legality, immediate reversals.
module pacman_direction_buffer #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         BUFFER_TICKS    = 8,
    parameter logic [3:0] RESET_DIR       = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       up_button,
    input  logic       down_button,
    input  logic [3:0] legal_moves,
    input  logic       move_tick,
    output logic [3:0] curr_direction,
    output logic [3:0] pending_dir,
    output logic       pending_valid,
    output logic       dir_changed,
    output logic       blocked
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(BUFFER_TICKS + 1);

    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    deb_q, deb_d;
    logic [3:0]    deb_prev_q, deb_prev_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [3:0]    dir_q, dir_d;
    logic [3:0]    pend_q, pend_d;
    logic          pv_q, pv_d;
    logic          chg_q, chg_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0]    edges;
    logic [3:0]    req;
    logic [3:0]    opp;
    logic          req_legal;
    logic          pend_legal;

    assign raw = {left_button, right_button, up_button, down_button};

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Only rising edges request a turn; coincident edges resolve L > R > U > D.
    assign edges = deb_q & ~deb_prev_q;

    always_comb begin
        req = 4'b0000;
        priority case (1'b1)
            edges[3]: req = 4'b1000;
            edges[2]: req = 4'b0100;
            edges[1]: req = 4'b0010;
            edges[0]: req = 4'b0001;
            default:  req = 4'b0000;
        endcase
    end

    assign opp        = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    assign req_legal  = |(req & legal_moves);
    assign pend_legal = |(pend_q & legal_moves);

    always_comb begin
        dir_d   = dir_q;
        pend_d  = pend_q;
        pv_d    = pv_q;
        timer_d = timer_q;
        chg_d   = 1'b0;
        if (|req) begin
            if (req == dir_q) begin
                dir_d = dir_q;
            end else if ((req == opp && req_legal) ||
                         (move_tick && req_legal)) begin
                dir_d  = req;
                pend_d = 4'b0000;
                pv_d   = 1'b0;
                chg_d  = 1'b1;
            end else begin
                pend_d  = req;
                pv_d    = 1'b1;
                timer_d = TW'(BUFFER_TICKS);
            end
        end else if (move_tick && pv_q) begin
            if (pend_legal) begin
                dir_d  = pend_q;
                pend_d = 4'b0000;
                pv_d   = 1'b0;
                chg_d  = 1'b1;
            end else if (timer_q == TW'(1)) begin
                pend_d = 4'b0000;
                pv_d   = 1'b0;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            dir_q   <= RESET_DIR;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            chg_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            chg_q   <= chg_d;
            timer_q <= timer_d;
        end
    end

    assign curr_direction = dir_q;
    assign pending_dir    = pend_q;
    assign pending_valid  = pv_q;
    assign dir_changed    = chg_q;
    assign blocked        = ~|(dir_q & legal_moves);
endmodule

// File: tb/tb_pacman_direction_buffer.sv
// Bench for pacman_direction_buffer: directed scenarios plus a random run
// against a window-based debounce / rule-based turn model.
module tb_pacman_direction_buffer;
    localparam int D  = 4;
    localparam int BT = 3;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] legal;
    logic       tick;
    logic [3:0] curr_direction;
    logic [3:0] pending_dir;
    logic       pending_valid;
    logic       dir_changed;
    logic       blocked;

    int checks;
    int errors;

    pacman_direction_buffer #(
        .DEBOUNCE_CYCLES(D),
        .BUFFER_TICKS(BT),
        .RESET_DIR(4'b1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .left_button(btn[3]),
        .right_button(btn[2]),
        .up_button(btn[1]),
        .down_button(btn[0]),
        .legal_moves(legal),
        .move_tick(tick),
        .curr_direction(curr_direction),
        .pending_dir(pending_dir),
        .pending_valid(pending_valid),
        .dir_changed(dir_changed),
        .blocked(blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: direction as bit index (3=L..0=D), opposite = idx^1.
    logic [3:0] m_s1, m_s2, m_deb, m_prev;
    logic [3:0] m_hist[$];
    int         m_dir, m_pidx, m_timer;
    bit         m_pv, m_chg;

    function automatic logic [3:0] onehot(int i);
        return 4'(1 << i);
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_prev = 0;
        m_hist.delete();
        m_dir = 3; m_pidx = 0; m_timer = 0;
        m_pv = 0; m_chg = 0;
    endtask

    task automatic model_step();
        logic [3:0] e;
        int req;
        bit all;
        if (rst) begin
            model_reset();
            return;
        end
        e = m_deb & ~m_prev;
        req = -1;
        for (int i = 3; i >= 0; i--) if (e[i] && req < 0) req = i;
        m_chg = 0;
        if (req >= 0) begin
            if (req != m_dir) begin
                if ((req == (m_dir ^ 1) || tick) && legal[req]) begin
                    m_dir = req; m_pv = 0; m_chg = 1;
                end else begin
                    m_pv = 1; m_pidx = req; m_timer = BT;
                end
            end
        end else if (tick && m_pv) begin
            if (legal[m_pidx]) begin
                m_dir = m_pidx; m_pv = 0; m_chg = 1;
            end else if (m_timer == 1) begin
                m_pv = 0;
            end else begin
                m_timer--;
            end
        end
        m_prev = m_deb;
        m_hist.push_back(m_s2);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        for (int i = 0; i < 4; i++) begin
            if (m_hist.size() == D) begin
                all = 1;
                foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) all = 0;
                if (all) m_deb[i] = ~m_deb[i];
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        btn = 0; tick = 0;
        for (int n = 0; n < 2; n++) begin
            legal = (n == 0) ? 4'b1001 : 4'b0111;
            do_reset();
            checks += 4;
            if (curr_direction !== 4'b1000) begin
                errors++;
                $display("FAIL reset_dir: got %b want 1000", curr_direction);
            end
            if (pending_valid !== 1'b0 || pending_dir !== 4'b0) begin
                errors++;
                $display("FAIL reset_pend: got %b/%b want 0/0000",
                         pending_valid, pending_dir);
            end
            if (dir_changed !== 1'b0) begin
                errors++;
                $display("FAIL reset_chg: got %b want 0", dir_changed);
            end
            if (blocked !== ~legal[3]) begin
                errors++;
                $display("FAIL reset_blocked: got %b want %b",
                         blocked, ~legal[3]);
            end
        end
    endtask

    task automatic test_glitch_latency();
        do_reset();
        legal = 4'b1000;
        btn[1] = 1'b1;
        repeat (3) step();
        btn[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (pending_valid !== 1'b0 || curr_direction !== 4'b1000) begin
                errors++;
                $display("FAIL glitch: got pv=%b dir=%b want 0/1000",
                         pending_valid, curr_direction);
            end
        end
        btn[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (pending_valid !== (i >= 7)) begin
                errors++;
                $display("FAIL latency_pv edge %0d: got %b want %b",
                         i, pending_valid, (i >= 7));
            end
            if (i == 7) begin
                checks++;
                if (pending_dir !== 4'b0010) begin
                    errors++;
                    $display("FAIL latency_pdir: got %b want 0010",
                             pending_dir);
                end
            end
        end
        btn[1] = 1'b0;
    endtask

    task automatic test_reversal();
        do_reset();
        legal = 4'b1100;
        btn[2] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks += 2;
            if (curr_direction !== ((i >= 7) ? 4'b0100 : 4'b1000)) begin
                errors++;
                $display("FAIL reversal_dir edge %0d: got %b", i,
                         curr_direction);
            end
            if (dir_changed !== (i == 7)) begin
                errors++;
                $display("FAIL reversal_chg edge %0d: got %b want %b",
                         i, dir_changed, (i == 7));
            end
        end
        btn[2] = 1'b0;
    endtask

    task automatic test_preturn();
        do_reset();
        legal = 4'b1000;
        btn[1] = 1'b1;
        repeat (7) step();
        btn[1] = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            legal = (t == 3) ? 4'b1010 : 4'b1000;
            tick = 1'b1;
            step();
            tick = 1'b0;
            checks += 2;
            if (curr_direction !== ((t == 3) ? 4'b0010 : 4'b1000)) begin
                errors++;
                $display("FAIL preturn_dir tick %0d: got %b", t,
                         curr_direction);
            end
            if (pending_valid !== (t < 3)) begin
                errors++;
                $display("FAIL preturn_pv tick %0d: got %b want %b",
                         t, pending_valid, (t < 3));
            end
            step();
        end
    endtask

    task automatic test_expire();
        do_reset();
        legal = 4'b1000;
        btn[0] = 1'b1;
        repeat (7) step();
        btn[0] = 1'b0;
        checks++;
        if (pending_dir !== 4'b0001) begin
            errors++;
            $display("FAIL expire_pdir: got %b want 0001", pending_dir);
        end
        for (int t = 1; t <= BT; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            checks += 2;
            if (pending_valid !== (t < BT)) begin
                errors++;
                $display("FAIL expire_pv tick %0d: got %b want %b",
                         t, pending_valid, (t < BT));
            end
            if (curr_direction !== 4'b1000) begin
                errors++;
                $display("FAIL expire_dir: got %b want 1000",
                         curr_direction);
            end
            step();
        end
    endtask

    task automatic test_coincide();
        do_reset();
        legal = 4'b1010;
        tick = 1'b1;
        btn[1] = 1'b1;
        repeat (8) step();
        tick = 1'b0;
        btn[1] = 1'b0;
        checks++;
        if (curr_direction !== 4'b0010) begin
            errors++;
            $display("FAIL coincide_setup: got %b want 0010", curr_direction);
        end
        repeat (D + 4) step();
        legal = 4'b1001;
        btn[3] = 1'b1;
        btn[0] = 1'b1;
        repeat (6) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks += 2;
        if (curr_direction !== 4'b1000 || dir_changed !== 1'b1) begin
            errors++;
            $display("FAIL coincide_dir: got %b chg=%b want 1000 chg=1",
                     curr_direction, dir_changed);
        end
        if (pending_valid !== 1'b0) begin
            errors++;
            $display("FAIL coincide_pv: got %b want 0", pending_valid);
        end
        step();
        checks++;
        if (curr_direction !== 4'b1000 || pending_valid !== 1'b0) begin
            errors++;
            $display("FAIL coincide_hold: got %b pv=%b want 1000 pv=0",
                     curr_direction, pending_valid);
        end
        btn = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        legal = 4'b1000;
        btn[1] = 1'b1;
        repeat (7) step();
        checks++;
        if (pending_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got %b want 1", pending_valid);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (pending_valid !== 1'b0 || curr_direction !== 4'b1000) begin
            errors++;
            $display("FAIL areset_now: got pv=%b dir=%b want 0/1000",
                     pending_valid, curr_direction);
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (pending_valid !== (i == 7)) begin
                errors++;
                $display("FAIL areset_fresh edge %0d: got %b want %b",
                         i, pending_valid, (i == 7));
            end
        end
        btn = 0;
    endtask

    task automatic test_random();
        logic [3:0] exp_p;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
            legal = 4'($urandom);
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end
            step();
            exp_p = m_pv ? onehot(m_pidx) : 4'b0;
            checks += 5;
            if (curr_direction !== onehot(m_dir)) begin
                errors++;
                $display("FAIL rand_dir @%0d: got %b want %b", n,
                         curr_direction, onehot(m_dir));
            end
            if (pending_valid !== m_pv) begin
                errors++;
                $display("FAIL rand_pv @%0d: got %b want %b", n,
                         pending_valid, m_pv);
            end
            if (pending_dir !== exp_p) begin
                errors++;
                $display("FAIL rand_pdir @%0d: got %b want %b", n,
                         pending_dir, exp_p);
            end
            if (dir_changed !== m_chg) begin
                errors++;
                $display("FAIL rand_chg @%0d: got %b want %b", n,
                         dir_changed, m_chg);
            end
            if (blocked !== ~|(onehot(m_dir) & legal)) begin
                errors++;
                $display("FAIL rand_blocked @%0d: got %b", n, blocked);
            end
        end
        btn = 0;
        tick = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        btn = 0;
        legal = 0;
        tick = 0;
        model_reset();
        test_reset();
        test_glitch_latency();
        test_reversal();
        test_preturn();
        test_expire();
        test_coincide();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
